// File: rtl/cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_seq_pkg
// Brief    : Shared types and constants for the Knight command sequencer:
//            acknowledge byte, FSM/error encodings and command constants that
//            benches reuse when building tour scripts.
// Revision : 1.0 - initial release
// ============================================================================
package cmd_seq_pkg;

  // Positive acknowledge byte returned by the Knight for a good command
  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_SNT  = 2'd2,
    WAIT_RESP = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_NAK   = 2'd1,
    ERR_TMO   = 2'd2,
    ERR_ABORT = 2'd3
  } err_code_t;

  // Command opcodes live in the top nibble of the 16-bit command word
  localparam logic [15:0] CAL_GYRO   = 16'h2000;
  localparam logic [3:0]  OP_MOVE    = 4'h4;
  localparam logic [3:0]  OP_FANFARE = 4'h5;

  // Heading field encodings for move commands
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Build a move command: {opcode, heading, squares}
  function automatic logic [15:0] mk_move(input logic [7:0] hdg,
                                          input logic [3:0] squares);
    return {OP_MOVE, hdg, squares};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_seq_player_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_seq_player_if
// Brief    : RemoteComm-style command handshake (cmd/snd_cmd out, cmd_snt,
//            resp_rdy, resp back). master = sequencer, slave = RemoteComm.
// Revision : 1.0 - initial release
// ============================================================================
interface cmd_seq_player_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output snd_cmd,
    input  cmd_snt,
    input  resp_rdy,
    input  resp
  );

  modport slave (
    input  cmd,
    input  snd_cmd,
    output cmd_snt,
    output resp_rdy,
    output resp
  );
endinterface
`default_nettype wire

// File: rtl/cmd_seq_mem.sv
`default_nettype none
// ============================================================================
// Module   : cmd_seq_mem
// Brief    : DEPTH x 16 command store. Appends on wr_en until full (further
//            writes are dropped), clr empties it, combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_seq_mem
  import cmd_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [15:0]              rd_data,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0] slots [DEPTH];
  logic        full;

  assign full    = (cnt == CW'(DEPTH));
  assign rd_data = slots[rd_idx];

  // Slot contents need no reset; only cnt defines which slots are valid
  always_ff @(posedge clk) begin
    if (wr_en && !clr && !full)
      slots[cnt[AW-1:0]] <= wr_data;
  end

  // Fill count: clr beats a simultaneous write, saturates at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (wr_en && !full)
      cnt <= cnt + CW'(1);
  end

endmodule
`default_nettype wire

// File: rtl/cmd_seq_player.sv
`default_nettype none
// ============================================================================
// Module   : cmd_seq_player
// Brief    : Replays a stored list of Knight commands over a RemoteComm-style
//            handshake, checking each response against POS_ACK with a
//            per-command timeout and bounded retries.
// Options  : CMD_SEQ_RESP_LOG_EN - adds a per-slot response log readable via
//            log_idx / log_data.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_seq_player
  import cmd_seq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TMO_CLKS  = 1000000,
  parameter int MAX_RETRY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     abort,
  cmd_seq_player_if.master         rc,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic [$clog2(DEPTH)-1:0] cmd_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code
`ifdef CMD_SEQ_RESP_LOG_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] log_idx,
  output logic [7:0]               log_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TMO_CLKS > 1) ? $clog2(TMO_CLKS) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  seq_state_t      state;
  logic [TW-1:0]   tmo_cnt;
  logic [RW-1:0]   retry;
  logic [15:0]     cmd_reg;
  logic            snd_cmd_reg;
  logic [AW-1:0]   rd_idx;
  logic [15:0]     rd_data;
  logic            start_ok;
  logic            resp_ok;
  logic            is_last;
  logic            tmo_hit;

  assign rc.cmd     = cmd_reg;
  assign rc.snd_cmd = snd_cmd_reg;

  assign start_ok = (state == IDLE) && start && (cnt != '0);
  // A response only counts in WAIT_RESP, and abort pre-empts it
  assign resp_ok  = (state == WAIT_RESP) && rc.resp_rdy && !abort;
  assign is_last  = ({1'b0, cmd_idx} == (cnt - CW'(1)));
  assign tmo_hit  = (tmo_cnt == TW'(TMO_CLKS - 1));

  // Read the slot that SEND will present next, so cmd and snd_cmd are
  // registered together on entry to SEND
  always_comb begin
    rd_idx = cmd_idx;
    if (state == IDLE)
      rd_idx = '0;
    else if (state == WAIT_RESP && rc.resp_rdy)
      rd_idx = cmd_idx + AW'(1);
  end

  cmd_seq_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && (state == IDLE)),
    .wr_data (wr_data),
    .clr     (clr && (state == IDLE)),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .cnt     (cnt)
  );

  // Playback FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      retry       <= '0;
      cmd_reg     <= '0;
      snd_cmd_reg <= 1'b0;
      cmd_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      snd_cmd_reg <= 1'b0;
      done        <= 1'b0;
      if (state != IDLE && abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= ERR_ABORT;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              state       <= SEND;
              busy        <= 1'b1;
              cmd_idx     <= '0;
              retry       <= '0;
              err         <= 1'b0;
              err_code    <= ERR_NONE;
              cmd_reg     <= rd_data;
              snd_cmd_reg <= 1'b1;
            end
          end
          SEND: begin
            state <= WAIT_SNT;
          end
          WAIT_SNT: begin
            // The UART always finishes, so no timeout here
            if (rc.cmd_snt) begin
              state   <= WAIT_RESP;
              tmo_cnt <= '0;
            end
          end
          WAIT_RESP: begin
            // A response on the timeout cycle still wins
            if (rc.resp_rdy) begin
              if (rc.resp == POS_ACK) begin
                if (is_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state       <= SEND;
                  cmd_idx     <= cmd_idx + AW'(1);
                  retry       <= '0;
                  cmd_reg     <= rd_data;
                  snd_cmd_reg <= 1'b1;
                end
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= ERR_NAK;
              end
            end else if (tmo_hit) begin
              if (retry < RW'(MAX_RETRY)) begin
                state       <= SEND;
                retry       <= retry + RW'(1);
                cmd_reg     <= rd_data;
                snd_cmd_reg <= 1'b1;
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= ERR_TMO;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CMD_SEQ_RESP_LOG_EN
  logic [7:0] log_mem [DEPTH];

  assign log_data = log_mem[log_idx];

  // Response log: wiped on each accepted start, one byte per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        log_mem[i] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < DEPTH; i++)
        log_mem[i] <= '0;
    end else if (resp_ok) begin
      log_mem[cmd_idx] <= rc.resp;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmd_seq_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_seq_player
// Brief    : Directed self-checking bench for cmd_seq_player (DEPTH=4,
//            TMO_CLKS=100, MAX_RETRY=2) acting as the RemoteComm responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_seq_player;
  import cmd_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 100;
  localparam int MR    = 2;
  // Spacing between resends: SEND + WAIT_SNT cycles plus the full timeout
  localparam int RESEND_GAP = 2 + TMO;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  cnt;
  logic [1:0]  cmd_idx;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
`ifdef CMD_SEQ_RESP_LOG_EN
  logic [1:0]  log_idx = '0;
  logic [7:0]  log_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int snd_cnt  = 0;
  int done_cnt = 0;

  cmd_seq_player_if rc_if ();

  always #5 clk = ~clk;

  cmd_seq_player #(
    .DEPTH     (DEPTH),
    .TMO_CLKS  (TMO),
    .MAX_RETRY (MR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr      (clr),
    .start    (start),
    .abort    (abort),
    .rc       (rc_if.master),
    .cnt      (cnt),
    .cmd_idx  (cmd_idx),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
`ifdef CMD_SEQ_RESP_LOG_EN
    ,
    .log_idx  (log_idx),
    .log_data (log_data)
`endif
  );

  // Cycle counter and pulse monitors
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rc_if.snd_cmd === 1'b1) snd_cnt <= snd_cnt + 1;
    if (done === 1'b1)          done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    wr_en = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_snd(output int c);
    int i = 0;
    while (rc_if.snd_cmd !== 1'b1 && i < 400) begin
      tick();
      i++;
    end
    chk("snd_cmd_seen", {31'd0, rc_if.snd_cmd}, 32'd1);
    c = cyc;
  endtask

  // Act as RemoteComm for one command: check cmd, complete transmit,
  // then optionally return a response byte
  task automatic serve(input logic [15:0] exp_cmd, input bit reply,
                       input logic [7:0] r, output int c);
    wait_snd(c);
    chk("cmd_value", {16'd0, rc_if.cmd}, {16'd0, exp_cmd});
    tick();
    chk("snd_cmd_one_clk", {31'd0, rc_if.snd_cmd}, 32'd0);
    rc_if.cmd_snt = 1'b1;
    tick();
    rc_if.cmd_snt = 1'b0;
    if (reply) begin
      rc_if.resp_rdy = 1'b1;
      rc_if.resp = r;
      tick();
      rc_if.resp_rdy = 1'b0;
    end
  endtask

  initial begin
    int c0, c1, c2, s0, d0;
    rc_if.cmd_snt  = 1'b0;
    rc_if.resp_rdy = 1'b0;
    rc_if.resp     = 8'h00;

    // Reset values
    tick();
    tick();
    chk("rst_cmd", {16'd0, rc_if.cmd}, 32'd0);
    chk("rst_snd_cmd", {31'd0, rc_if.snd_cmd}, 32'd0);
    chk("rst_cnt", {29'd0, cnt}, 32'd0);
    chk("rst_cmd_idx", {30'd0, cmd_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Two commands, both acknowledged
    load(CAL_GYRO);
    load(mk_move(HDG_N, 4'd4));
    chk("t1_cnt", {29'd0, cnt}, 32'd2);
    s0 = snd_cnt;
    d0 = done_cnt;
    do_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    serve(16'h2000, 1'b1, 8'hA5, c0);
    chk("t1_mid_done", {31'd0, done}, 32'd0);
    serve(16'h4004, 1'b1, 8'hA5, c1);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_fall", {31'd0, busy}, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_err_code", {30'd0, err_code}, 32'd0);
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    tick();
    chk("t1_snd_count", snd_cnt - s0, 32'd2);
    chk("t1_done_count", done_cnt - d0, 32'd1);

    // Three commands, NAK on the second
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2_clr_cnt", {29'd0, cnt}, 32'd0);
    load(16'h2000);
    load(16'h4004);
    load(16'h4008);
    chk("t2_cnt", {29'd0, cnt}, 32'd3);
    s0 = snd_cnt;
    d0 = done_cnt;
    do_start();
    serve(16'h2000, 1'b1, 8'hA5, c0);
    serve(16'h4004, 1'b1, 8'h5A, c1);
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_err_code", {30'd0, err_code}, 32'd1);
    chk("t2_cmd_idx", {30'd0, cmd_idx}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    chk("t2_snd_count", snd_cnt - s0, 32'd2);
    chk("t2_no_done", done_cnt - d0, 32'd0);
    chk("t2_err_sticky", {31'd0, err}, 32'd1);
`ifdef CMD_SEQ_RESP_LOG_EN
    log_idx = 2'd0;
    #1;
    chk("t2_log0", {24'd0, log_data}, 32'hA5);
    log_idx = 2'd1;
    #1;
    chk("t2_log1", {24'd0, log_data}, 32'h5A);
`endif

    // Silent responder: initial send plus two retries, then TIMEOUT
    clr = 1'b1;
    tick();
    clr = 1'b0;
    load(16'h2000);
    load(16'h4004);
    s0 = snd_cnt;
    do_start();
    chk("t3_err_cleared", {31'd0, err}, 32'd0);
    serve(16'h2000, 1'b0, 8'h00, c0);
    serve(16'h2000, 1'b0, 8'h00, c1);
    chk("t3_gap1", c1 - c0, RESEND_GAP);
    serve(16'h2000, 1'b0, 8'h00, c2);
    chk("t3_gap2", c2 - c1, RESEND_GAP);
    repeat (TMO - 1) tick();
    chk("t3_busy_before_tmo", {31'd0, busy}, 32'd1);
    chk("t3_err_before_tmo", {31'd0, err}, 32'd0);
    tick();
    chk("t3_busy_after_tmo", {31'd0, busy}, 32'd0);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_err_code", {30'd0, err_code}, 32'd2);
    chk("t3_cmd_idx", {30'd0, cmd_idx}, 32'd0);
    tick();
    chk("t3_snd_count", snd_cnt - s0, 32'd3);

    // Silent first, ack on the retry, playback continues
    do_start();
    chk("t4_err_clear", {31'd0, err}, 32'd0);
    chk("t4_err_code_clear", {30'd0, err_code}, 32'd0);
    serve(16'h2000, 1'b0, 8'h00, c0);
    serve(16'h2000, 1'b1, 8'hA5, c1);
    chk("t4_gap", c1 - c0, RESEND_GAP);
    serve(16'h4004, 1'b1, 8'hA5, c2);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_err", {31'd0, err}, 32'd0);

    // Abort in WAIT_SNT, then restart from slot 0
    tick();
    d0 = done_cnt;
    do_start();
    wait_snd(c0);
    tick();
    chk("t5_busy_wait_snt", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_err_code", {30'd0, err_code}, 32'd3);
    tick();
    chk("t5_no_done", done_cnt - d0, 32'd0);
    do_start();
    chk("t5_restart_err", {31'd0, err}, 32'd0);
    chk("t5_restart_code", {30'd0, err_code}, 32'd0);
    chk("t5_restart_idx", {30'd0, cmd_idx}, 32'd0);
    serve(16'h2000, 1'b1, 8'hA5, c0);
    serve(16'h4004, 1'b1, 8'hA5, c1);
    chk("t5_done", {31'd0, done}, 32'd1);

    // Saturation, clr beats wr_en, start with empty list, abort in IDLE
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    load(16'h1001);
    load(16'h1002);
    load(16'h1003);
    load(16'h1004);
    load(16'h1005);
    chk("t6_cnt_sat", {29'd0, cnt}, 32'd4);
    wr_en = 1'b1;
    wr_data = 16'h1006;
    clr = 1'b1;
    tick();
    wr_en = 1'b0;
    clr = 1'b0;
    chk("t6_clr_wins", {29'd0, cnt}, 32'd0);
    s0 = snd_cnt;
    do_start();
    chk("t6_empty_start_busy", {31'd0, busy}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_idle_abort_err", {31'd0, err}, 32'd0);
    repeat (3) tick();
    chk("t6_busy_stays", {31'd0, busy}, 32'd0);
    chk("t6_no_snd", snd_cnt - s0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
